pipeline_hazard_ctrl: RTL and testbench

Stall/flush sequencer for the 5-stage forwarding pipeline. It detects load-use hazards that forwarding cannot resolve, inserts the required bubbles, and squashes wrong-path instructions after a taken branch. It also freezes the whole pipeline while data memory is busy. It sits beside the forwarding unit, drives the PC and pipeline-register write enables, and consumes ID- and EX-stage register fields.

---
 rtl/pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Load-use stall / branch flush / memory freeze sequencer for the
//             5-stage forwarding pipeline. HAZARD_PERF_EN builds perf counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int BRANCH_PENALTY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_dx,
    input  logic [4:0]  rd_register_dx,
    input  logic [4:0]  rs_register_fd,
    input  logic [4:0]  rt_register_fd,
    input  logic        uses_rt_fd,
    input  logic        branch_taken_dx,
    input  logic        dmem_busy,
    output logic        pc_write,
    output logic        fd_write,
    output logic        dx_write,
    output logic        xm_write,
    output logic        fd_flush,
    output logic        dx_bubble,
    output logic [1:0]  ctrl_state,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_RSVD       = 2'd3
    } state_t;

    localparam logic [1:0] c_stall_init = 2'(LOAD_USE_BUBBLES - 1);
    localparam logic [1:0] c_flush_init = 2'(BRANCH_PENALTY - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic       w_hz;
    logic       w_stall_inc;
    logic       w_flush_inc;

    assign w_hz = mem_read_dx && (rd_register_dx != 5'd0) &&
                  ((rd_register_dx == rs_register_fd) ||
                   (uses_rt_fd && (rd_register_dx == rt_register_fd)));

    // Mealy decode: outputs react in the same cycle the condition is seen
    always_comb begin
        pc_write    = 1'b1;
        fd_write    = 1'b1;
        dx_write    = 1'b1;
        xm_write    = 1'b1;
        fd_flush    = 1'b0;
        dx_bubble   = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        if (!rst_n) begin
            pc_write  = 1'b0;
            fd_write  = 1'b0;
            dx_write  = 1'b0;
            xm_write  = 1'b0;
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
        end else if (dmem_busy) begin
            pc_write = 1'b0;
            fd_write = 1'b0;
            dx_write = 1'b0;
            xm_write = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken_dx) begin
                        fd_flush    = 1'b1;
                        dx_bubble   = 1'b1;
                        w_flush_inc = 1'b1;
                        if (BRANCH_PENALTY > 1) begin
                            w_state_nxt = ST_FLUSH;
                            w_cnt_nxt   = c_flush_init;
                        end
                    end else if (w_hz) begin
                        pc_write    = 1'b0;
                        fd_write    = 1'b0;
                        dx_bubble   = 1'b1;
                        w_stall_inc = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            w_state_nxt = ST_LOAD_STALL;
                            w_cnt_nxt   = c_stall_init;
                        end
                    end
                end
                ST_LOAD_STALL: begin
                    pc_write    = 1'b0;
                    fd_write    = 1'b0;
                    dx_bubble   = 1'b1;
                    w_stall_inc = 1'b1;
                    w_cnt_nxt   = r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    fd_flush  = 1'b1;
                    w_cnt_nxt = r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign ctrl_state = r_state;

`ifdef HAZARD_PERF_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    // Counters saturate rather than wrap so long runs stay monotonic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= 16'h0000;
            r_flush_count <= 16'h0000;
        end else begin
            if (w_stall_inc && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'h0001;
            end
            if (w_flush_inc && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'h0001;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`else
    logic w_unused_perf;
    assign w_unused_perf = w_stall_inc ^ w_flush_inc;
    assign stall_count   = 16'h0000;
    assign flush_count   = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Brief    : Two DUT configurations (2/2 and 3/1) checked against a
//             remaining-cycles model every cycle plus literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_read_dx = 1'b0;
    logic [4:0] rd_register_dx = 5'd0;
    logic [4:0] rs_register_fd = 5'd0;
    logic [4:0] rt_register_fd = 5'd0;
    logic       uses_rt_fd = 1'b0;
    logic       branch_taken_dx = 1'b0;
    logic       dmem_busy = 1'b0;

    logic        pc_a, fd_a, dxw_a, xm_a, fl_a, bb_a;
    logic [1:0]  st_a;
    logic [15:0] sc_a, fc_a;
    logic        pc_b, fd_b, dxw_b, xm_b, fl_b, bb_b;
    logic [1:0]  st_b;
    logic [15:0] sc_b, fc_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_USE_BUBBLES(2), .BRANCH_PENALTY(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .mem_read_dx(mem_read_dx),
        .rd_register_dx(rd_register_dx), .rs_register_fd(rs_register_fd),
        .rt_register_fd(rt_register_fd), .uses_rt_fd(uses_rt_fd),
        .branch_taken_dx(branch_taken_dx), .dmem_busy(dmem_busy),
        .pc_write(pc_a), .fd_write(fd_a), .dx_write(dxw_a), .xm_write(xm_a),
        .fd_flush(fl_a), .dx_bubble(bb_a), .ctrl_state(st_a),
        .stall_count(sc_a), .flush_count(fc_a)
    );

    pipeline_hazard_ctrl #(.LOAD_USE_BUBBLES(3), .BRANCH_PENALTY(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .mem_read_dx(mem_read_dx),
        .rd_register_dx(rd_register_dx), .rs_register_fd(rs_register_fd),
        .rt_register_fd(rt_register_fd), .uses_rt_fd(uses_rt_fd),
        .branch_taken_dx(branch_taken_dx), .dmem_busy(dmem_busy),
        .pc_write(pc_b), .fd_write(fd_b), .dx_write(dxw_b), .xm_write(xm_b),
        .fd_flush(fl_b), .dx_bubble(bb_b), .ctrl_state(st_b),
        .stall_count(sc_b), .flush_count(fc_b)
    );

    // {pc_write, fd_write, dx_write, xm_write, fd_flush, dx_bubble, ctrl_state}
    logic [7:0] act_a, act_b;
    assign act_a = {pc_a, fd_a, dxw_a, xm_a, fl_a, bb_a, st_a};
    assign act_b = {pc_b, fd_b, dxw_b, xm_b, fl_b, bb_b, st_b};

    // Model: remaining stall/flush cycles per instance and event totals
    int m_stall [2] = '{0, 0};
    int m_flush [2] = '{0, 0};
    int m_scnt  [2] = '{0, 0};
    int m_fcnt  [2] = '{0, 0};

    function automatic int bubbles_of(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int penalty_of(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic logic model_hz();
        return mem_read_dx && (rd_register_dx != 0) &&
               ((rd_register_dx == rs_register_fd) ||
                (uses_rt_fd && (rd_register_dx == rt_register_fd)));
    endfunction

    function automatic logic [7:0] model_ctrl(int i);
        logic [1:0] s;
        s = (m_stall[i] > 0) ? 2'd1 : (m_flush[i] > 0) ? 2'd2 : 2'd0;
        if (!rst_n)           return 8'b0000_11_00;
        if (dmem_busy)        return {6'b0000_00, s};
        if (m_stall[i] > 0)   return 8'b0011_01_01;
        if (m_flush[i] > 0)   return 8'b1111_10_10;
        if (branch_taken_dx)  return 8'b1111_11_00;
        if (model_hz())       return 8'b0011_01_00;
        return 8'b1111_00_00;
    endfunction

    function automatic int sat_inc(int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    m_stall[i] = 0;
                    m_flush[i] = 0;
                    m_scnt[i]  = 0;
                    m_fcnt[i]  = 0;
                end else if (!dmem_busy) begin
                    if (m_stall[i] > 0) begin
                        m_stall[i]--;
                        m_scnt[i] = sat_inc(m_scnt[i]);
                    end else if (m_flush[i] > 0) begin
                        m_flush[i]--;
                    end else if (branch_taken_dx) begin
                        m_fcnt[i]  = sat_inc(m_fcnt[i]);
                        m_flush[i] = penalty_of(i) - 1;
                    end else if (model_hz()) begin
                        m_scnt[i]  = sat_inc(m_scnt[i]);
                        m_stall[i] = bubbles_of(i) - 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("ctrl_a", {8'h00, act_a}, {8'h00, model_ctrl(0)});
            check("ctrl_b", {8'h00, act_b}, {8'h00, model_ctrl(1)});
`ifdef HAZARD_PERF_EN
            check("stall_cnt_a", sc_a, 16'(m_scnt[0]));
            check("flush_cnt_a", fc_a, 16'(m_fcnt[0]));
            check("stall_cnt_b", sc_b, 16'(m_scnt[1]));
            check("flush_cnt_b", fc_b, 16'(m_fcnt[1]));
`else
            check("stall_cnt_a", sc_a, 16'h0000);
            check("flush_cnt_b", fc_b, 16'h0000);
`endif
        end
    end

    task automatic apply(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic br,
                         input logic busy);
        @(posedge clk);
        #1;
        mem_read_dx     = mr;
        rd_register_dx  = rd;
        rs_register_fd  = rs;
        rt_register_fd  = rt;
        uses_rt_fd      = urt;
        branch_taken_dx = br;
        dmem_busy       = busy;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog t=%0t got=running expected=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int na, nb;
        idle();
        idle();
        check("reset_out_a", {8'h00, act_a}, 16'h000C);
        check("reset_out_b", {8'h00, act_b}, 16'h000C);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        check("run_idle_a", {8'h00, act_a}, 16'h00F0);

        // Load-use on rs: A stalls 2 cycles, B stalls 3
        apply(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        check("hz_first_a", {8'h00, act_a}, 16'h0034);
        na = (pc_a == 1'b0) ? 1 : 0;
        nb = (pc_b == 1'b0) ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            idle();
            if (k == 0) check("hz_second_a", {8'h00, act_a}, 16'h0035);
            na += (pc_a == 1'b0) ? 1 : 0;
            nb += (pc_b == 1'b0) ? 1 : 0;
        end
        check("stall_len_a", 16'(na), 16'd2);
        check("stall_len_b", 16'(nb), 16'd3);
`ifdef HAZARD_PERF_EN
        check("lit_stall_a", sc_a, 16'd2);
        check("lit_stall_b", sc_b, 16'd3);
`endif

        // rd = 0 never hazards
        apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("rd_zero_a", {8'h00, act_a}, 16'h00F0);
        check("rd_zero_b", {8'h00, act_b}, 16'h00F0);

        // rt match counts only when rt is read
        apply(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        check("rt_unused", {8'h00, act_a}, 16'h00F0);
        apply(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        check("rt_used", {8'h00, act_a}, 16'h0034);
        repeat (3) idle();

        // Branch wins over a simultaneous hazard
        apply(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0);
        check("br_first_a", {8'h00, act_a}, 16'h00FC);
        check("br_first_b", {8'h00, act_b}, 16'h00FC);
        idle();
        check("br_second_a", {8'h00, act_a}, 16'h00FA);
        check("br_second_b", {8'h00, act_b}, 16'h00F0);
        idle();
        check("br_done_a", {8'h00, act_a}, 16'h00F0);
`ifdef HAZARD_PERF_EN
        check("lit_flush_a", fc_a, 16'd1);
        check("lit_stall_br_a", sc_a, 16'd4);
        check("lit_stall_br_b", sc_b, 16'd6);
`endif

        // Freeze in the middle of a stall does not consume bubbles
        apply(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        check("frz_entry_b", {8'h00, act_b}, 16'h0034);
        repeat (4) begin
            apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
            check("frz_b", {8'h00, act_b}, 16'h0001);
            check("frz_a", {8'h00, act_a}, 16'h0001);
        end
        idle();
        check("frz_post1_b", {8'h00, act_b}, 16'h0035);
        check("frz_post1_a", {8'h00, act_a}, 16'h0035);
        idle();
        check("frz_post2_b", {8'h00, act_b}, 16'h0035);
        check("frz_post2_a", {8'h00, act_a}, 16'h00F0);
        idle();
        check("frz_done_b", {8'h00, act_b}, 16'h00F0);

        // Branch during freeze is not taken
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        check("frz_br_a", {8'h00, act_a}, 16'h0000);
        idle();
        check("frz_br_after_a", {8'h00, act_a}, 16'h00F0);

        // Reset mid-flush aborts immediately
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        branch_taken_dx = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_flush_a", {8'h00, act_a}, 16'h000C);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        check("post_rst_a", {8'h00, act_a}, 16'h00F0);
        apply(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
        check("post_rst_hz_a", {8'h00, act_a}, 16'h0034);
        repeat (3) idle();

`ifdef HAZARD_PERF_EN
        // Continuous hazard stalls every cycle; drives counters to saturation
        for (int k = 0; k < 65540; k++) begin
            apply(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        end
        check("sat_stall_a", sc_a, 16'hFFFF);
        check("sat_stall_b", sc_b, 16'hFFFF);
        repeat (3) idle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
